// File: rtl/vs_inhibit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vs_inhibit_pkg
// Purpose  : Shared state encoding, counter width and helpers for inhibit_ctrl.
// Revision : 1.0
// ============================================================================
package vs_inhibit_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DEBOUNCE = 2'b01,
        ON       = 2'b10,
        HOLDOFF  = 2'b11
    } inhibit_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff2.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff2
// Purpose  : Two-flop synchronizer for a single asynchronous level.
// Revision : 1.0
// ============================================================================
module sync_ff2 (
    input  logic clk,
    input  logic reset_l,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/inhibit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inhibit_ctrl
// Purpose  : Debounced enable window with max-on timeout and forced holdoff.
//            Define INHIBIT_CTRL_SYNC_EN to synchronize req through sync_ff2.
// Revision : 1.0
// ============================================================================
module inhibit_ctrl
    import vs_inhibit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int MAX_ON_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       req,
    input  logic       force_inhibit,
    output logic       enable_l,
    output logic [1:0] state,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE     = 2'(IDLE);
    localparam logic [1:0] ST_DEBOUNCE = 2'(DEBOUNCE);
    localparam logic [1:0] ST_ON       = 2'(ON);
    localparam logic [1:0] ST_HOLDOFF  = 2'(HOLDOFF);

    localparam logic [CNT_W-1:0] c_deb    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_hold   = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] c_max_on = CNT_W'(MAX_ON_CYCLES);
    localparam logic             c_max_en = (MAX_ON_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    logic             w_req_s;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_enable_l;
    logic             r_timeout;
    logic             w_timeout_nx;

`ifdef INHIBIT_CTRL_SYNC_EN
    sync_ff2 u_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .d       (req),
        .q       (w_req_s)
    );
`else
    assign w_req_s = req;
`endif

    // force_inhibit is tested first in every state so it wins over req_s.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_timeout_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (force_inhibit) begin
                    w_cnt_nx = '0;
                end else if (w_req_s) begin
                    w_state_nx = ST_DEBOUNCE;
                    w_cnt_nx   = c_one;
                end
            end
            ST_DEBOUNCE: begin
                if (force_inhibit || !w_req_s) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_deb) begin
                    w_state_nx = ST_ON;
                    w_cnt_nx   = c_one;
                end else begin
                    w_cnt_nx = sat_inc(r_cnt);
                end
            end
            ST_ON: begin
                if (force_inhibit || !w_req_s) begin
                    w_state_nx = ST_HOLDOFF;
                    w_cnt_nx   = c_one;
                end else if (c_max_en && (r_cnt == c_max_on)) begin
                    w_state_nx   = ST_HOLDOFF;
                    w_cnt_nx     = c_one;
                    w_timeout_nx = 1'b1;
                end else begin
                    w_cnt_nx = sat_inc(r_cnt);
                end
            end
            ST_HOLDOFF: begin
                if (force_inhibit) begin
                    w_cnt_nx = c_one;
                end else if (r_cnt == c_hold) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = sat_inc(r_cnt);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // enable_l is decoded from the next state so it is a clean flop output.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_enable_l <= 1'b1;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_enable_l <= (w_state_nx != ST_ON);
            r_timeout  <= w_timeout_nx;
        end
    end

    assign enable_l = r_enable_l;
    assign state    = r_state;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire
